// File: rtl/t_ff_pkg.sv
// ============================================================================
//  Module      : t_ff_pkg
//  Description : Shared count-direction encodings and the load clamp helper
//                for the T flip-flop counter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package t_ff_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Widest counter supported; the clamp helper works at this width.
    localparam int MAX_WIDTH = 16;

    function automatic logic [MAX_WIDTH-1:0] clamp(
        input logic [MAX_WIDTH-1:0] val,
        input logic [MAX_WIDTH-1:0] max_val
    );
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/t_ff_counter_if.sv
// ============================================================================
//  Module      : t_ff_counter_if
//  Description : Control/status bundle of the T flip-flop counter.
//                Carries the sat flag only when T_FF_COUNTER_SAT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface t_ff_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t_vec;
    logic             tc;
    logic             wrap;
`ifdef T_FF_COUNTER_SAT_EN
    logic             sat;
`endif

    modport master (
        output en, up_dn, load, load_val,
`ifdef T_FF_COUNTER_SAT_EN
        input  sat,
`endif
        input  q, t_vec, tc, wrap
    );

    modport slave (
        input  en, up_dn, load, load_val,
`ifdef T_FF_COUNTER_SAT_EN
        output sat,
`endif
        output q, t_vec, tc, wrap
    );

endinterface

`default_nettype wire

// File: rtl/t_ff_cell.sv
// ============================================================================
//  Module      : t_ff_cell
//  Description : Single T flip-flop bit with a direct-set path that overrides
//                the toggle input.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module t_ff_cell (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic t,
    input  wire logic set_en,
    input  wire logic set_val,
    output logic      q
);

    logic r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= 1'b0;
        end else if (set_en) begin
            r_q <= set_val;
        end else begin
            r_q <= r_q ^ t;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/t_ff_counter.sv
// ============================================================================
//  Module      : t_ff_counter
//  Description : Modulo-(MAX_COUNT+1) up/down counter made of T flip-flop
//                cells. Define T_FF_COUNTER_SAT_EN to saturate at terminal
//                count instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module t_ff_counter
    import t_ff_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = (1 << WIDTH) - 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    t_ff_counter_if.slave   bus
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_set_val;
    logic [WIDTH-1:0] w_load_val;
    logic             w_set_en;
    logic             w_dir_up;
    logic             w_at_tc;
    logic             w_wrap_next;
    logic             r_wrap;

    assign w_dir_up   = (bus.up_dn == CNT_UP);
    assign w_at_tc    = w_dir_up ? (w_q == c_max) : (w_q == '0);
    assign w_load_val = WIDTH'(clamp(MAX_WIDTH'(bus.load_val), MAX_WIDTH'(MAX_COUNT)));

    // Ripple of "all lower bits are 1" (up) or "all lower bits are 0" (down).
    always_comb begin
        logic chain;
        chain       = 1'b1;
        w_toggle    = '0;
        w_toggle[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            chain       = chain & (w_dir_up ? w_q[i-1] : ~w_q[i-1]);
            w_toggle[i] = chain;
        end
    end

    always_comb begin
        w_t         = '0;
        w_set_en    = 1'b0;
        w_set_val   = '0;
        w_wrap_next = 1'b0;
        if (bus.load) begin
            w_set_en  = 1'b1;
            w_set_val = w_load_val;
        end else if (bus.en) begin
            if (!w_at_tc) begin
                w_t = w_toggle;
            end
`ifndef T_FF_COUNTER_SAT_EN
            // Wrap always goes through the set path so a non-power-of-two
            // modulus and the full range behave identically.
            else begin
                w_set_en    = 1'b1;
                w_set_val   = w_dir_up ? '0 : c_max;
                w_wrap_next = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        t_ff_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .t       (w_t[gi]),
            .set_en  (w_set_en),
            .set_val (w_set_val[gi]),
            .q       (w_q[gi])
        );
    end

    assign bus.q     = w_q;
    assign bus.t_vec = w_t;
    assign bus.tc    = w_at_tc;
    assign bus.wrap  = r_wrap;
`ifdef T_FF_COUNTER_SAT_EN
    assign bus.sat   = bus.en & w_at_tc & ~bus.load;
`endif

endmodule

`default_nettype wire

// File: tb/tb_t_ff_counter.sv
// ============================================================================
//  Module      : tb_t_ff_counter
//  Description : Scoreboard bench for t_ff_counter (WIDTH=4, MAX_COUNT=9).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_t_ff_counter;

    localparam int WIDTH = 4;
    localparam int MAXC  = 9;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    t_ff_counter_if #(.WIDTH(WIDTH)) bus ();

    t_ff_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAXC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int q;
        int wrap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_q    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, check the combinational outputs, queue the registered result.
    task automatic step(input logic e, input logic u, input logic l, input int lv);
        int at_tc;
        int exp_tv;
        int nq;
        int nw;
        @(negedge clk);
        bus.en       = e;
        bus.up_dn    = u;
        bus.load     = l;
        bus.load_val = lv[WIDTH-1:0];
        #1;
        at_tc = u ? int'(m_q == MAXC) : int'(m_q == 0);
        if (l || !e || at_tc != 0) exp_tv = 0;
        else exp_tv = (u ? (m_q ^ (m_q + 1)) : (m_q ^ (m_q - 1))) & ((1 << WIDTH) - 1);
        chk("tc", int'(bus.tc), at_tc);
        chk("t_vec", int'(bus.t_vec), exp_tv);
`ifdef T_FF_COUNTER_SAT_EN
        chk("sat", int'(bus.sat), int'(e && !l && at_tc != 0));
`endif
        nq = m_q;
        nw = 0;
        if (l) begin
            nq = (lv > MAXC) ? MAXC : lv;
        end else if (e) begin
            if (at_tc != 0) begin
`ifndef T_FF_COUNTER_SAT_EN
                nq = u ? 0 : MAXC;
                nw = 1;
`endif
            end else begin
                nq = u ? m_q + 1 : m_q - 1;
            end
        end
        m_q = nq;
        sb.push_back('{q: nq, wrap: nw});
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", int'(bus.q), e.q);
                chk("wrap", int'(bus.wrap), e.wrap);
            end
        end
    end

    initial begin
        bus.en       = 1'b1;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // Reset held with en=1 for three edges.
        #2;
        chk("rst_q", int'(bus.q), 0);
        chk("rst_wrap", int'(bus.wrap), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold_q", int'(bus.q), 0);
            chk("rst_hold_wrap", int'(bus.wrap), 0);
        end

        // Release between edges: nothing moves until the next rising edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rel_q", int'(bus.q), 0);
        m_q = 1;
        sb.push_back('{q: 1, wrap: 0});

        // Up count through the 9 -> 0 wrap.
        repeat (11) step(1'b1, 1'b1, 1'b0, 0);

        // Load 3 then count down through 0 -> 9.
        step(1'b0, 1'b1, 1'b1, 3);
        repeat (5) step(1'b1, 1'b0, 1'b0, 0);

        // Out-of-range load clamps and beats en.
        step(1'b1, 1'b1, 1'b1, 15);
        step(1'b1, 1'b1, 1'b0, 0);

        // From 8 upward: wraps, or saturates in the saturating build.
        step(1'b0, 1'b1, 1'b1, 8);
        repeat (3) step(1'b1, 1'b1, 1'b0, 0);

        repeat (300) begin
            step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)));
        end

        // Asynchronous reset between edges.
        step(1'b0, 1'b1, 1'b1, 6);
        @(posedge clk);
        #3;
        chk("pre_async_q", int'(bus.q), 6);
        bus.load = 1'b0;
        reset    = 1'b0;
        #1;
        chk("async_q", int'(bus.q), 0);
        chk("async_wrap", int'(bus.wrap), 0);
        m_q = 0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (4) step(1'b1, 1'b1, 1'b0, 0);

        @(posedge clk);
        #2;
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
